// File: rtl/frame_timing_ctrl.sv
// frame_timing_ctrl: frame/line timing scheduler ahead of the pattern Control FSM.
// Generates f_sync/sync/endLine/endFrame strobes, paces pixels against a
// downstream ready, inserts horizontal blanking, and latches Mode per frame.
// Optional feature: define CONTINUOUS_EN for back-to-back frames (only abort
// returns to IDLE); the default build runs one frame per accepted start.
module frame_timing_ctrl #(
  parameter int PIX_PER_LINE    = 1290,
  parameter int LINES_PER_FRAME = 4,
  parameter int HBLANK          = 8,
  parameter int PIX_W           = 11,
  parameter int LINE_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        mode_in,
  input  logic              ready,
  output logic              f_sync,
  output logic              sync,
  output logic              endLine,
  output logic              endFrame,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_cnt,
  output logic [LINE_W-1:0] line_cnt,
  output logic [2:0]        Mode,
  output logic              busy,
  output logic              mode_err
);

  localparam int BLANK_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FSYNC  = 2'd1,
    S_LINE   = 2'd2,
    S_HBLANK = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [PIX_W-1:0]    pix_cnt_reg, pix_cnt_next;
  logic [LINE_W-1:0]   line_cnt_reg, line_cnt_next;
  logic [BLANK_W-1:0]  blank_cnt_reg, blank_cnt_next;
  logic [2:0]          mode_reg, mode_next;
  logic                mode_err_reg, mode_err_next;

  logic last_pix;
  logic last_line;
  logic last_blank;
  logic line_done;

  assign last_pix   = (pix_cnt_reg == PIX_W'(PIX_PER_LINE - 1));
  assign last_line  = (line_cnt_reg == LINE_W'(LINES_PER_FRAME - 1));
  assign last_blank = (blank_cnt_reg == BLANK_W'(HBLANK - 1));
  // The final beat of a line is only real when it is accepted; abort wins over it.
  assign line_done  = (state_reg == S_LINE) && ready && last_pix && !abort;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      pix_cnt_reg   <= '0;
      line_cnt_reg  <= '0;
      blank_cnt_reg <= '0;
      mode_reg      <= '0;
      mode_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pix_cnt_reg   <= pix_cnt_next;
      line_cnt_reg  <= line_cnt_next;
      blank_cnt_reg <= blank_cnt_next;
      mode_reg      <= mode_next;
      mode_err_reg  <= mode_err_next;
    end
  end

  // Next-state and counter update; abort overrides everything except Mode.
  always_comb begin
    state_next     = state_reg;
    pix_cnt_next   = pix_cnt_reg;
    line_cnt_next  = line_cnt_reg;
    blank_cnt_next = blank_cnt_reg;
    mode_next      = mode_reg;
    mode_err_next  = 1'b0;
    if (abort) begin
      state_next     = S_IDLE;
      pix_cnt_next   = '0;
      line_cnt_next  = '0;
      blank_cnt_next = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (mode_in != 3'd0) state_next    = S_FSYNC;
            else                 mode_err_next = 1'b1;
          end
        end
        S_FSYNC: begin
          mode_next      = mode_in;
          pix_cnt_next   = '0;
          line_cnt_next  = '0;
          blank_cnt_next = '0;
          state_next     = S_LINE;
        end
        S_LINE: begin
          if (ready) begin
            if (last_pix) begin
              pix_cnt_next   = '0;
              blank_cnt_next = '0;
              if (last_line) begin
                line_cnt_next = '0;
`ifdef CONTINUOUS_EN
                state_next    = S_FSYNC;
`else
                state_next    = S_IDLE;
`endif
              end else begin
                state_next    = S_HBLANK;
              end
            end else begin
              pix_cnt_next = pix_cnt_reg + PIX_W'(1);
            end
          end
        end
        S_HBLANK: begin
          if (last_blank) begin
            blank_cnt_next = '0;
            line_cnt_next  = line_cnt_reg + LINE_W'(1);
            state_next     = S_LINE;
          end else begin
            blank_cnt_next = blank_cnt_reg + BLANK_W'(1);
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Strobes decode from the registered state; end-of-line also needs the accepting ready.
  assign f_sync    = (state_reg == S_FSYNC) && !abort;
  assign sync      = ((state_reg == S_FSYNC) ||
                      ((state_reg == S_HBLANK) && last_blank)) && !abort;
  assign endLine   = line_done;
  assign endFrame  = line_done && last_line;
  assign pix_valid = (state_reg == S_LINE);
  assign busy      = (state_reg != S_IDLE);
  assign pix_cnt   = pix_cnt_reg;
  assign line_cnt  = line_cnt_reg;
  assign Mode      = mode_reg;
  assign mode_err  = mode_err_reg;

endmodule

// File: tb/tb_frame_timing_ctrl.sv
// tb_frame_timing_ctrl: table-driven frame check plus hand-written corner sequences
// for frame_timing_ctrl with PIX_PER_LINE=4, LINES_PER_FRAME=3, HBLANK=2.
module tb_frame_timing_ctrl;

  localparam int PPL = 4;
  localparam int LPF = 3;
  localparam int HB  = 2;
  localparam int PW  = 11;
  localparam int LW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, ready;
  logic [2:0]    mode_in;
  logic          f_sync, sync, endLine, endFrame, pix_valid, busy, mode_err;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt;
  logic [2:0]    Mode;

  int total = 0;
  int bad   = 0;

  frame_timing_ctrl #(
    .PIX_PER_LINE(PPL), .LINES_PER_FRAME(LPF), .HBLANK(HB), .PIX_W(PW), .LINE_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode_in(mode_in),
    .ready(ready), .f_sync(f_sync), .sync(sync), .endLine(endLine),
    .endFrame(endFrame), .pix_valid(pix_valid), .pix_cnt(pix_cnt),
    .line_cnt(line_cnt), .Mode(Mode), .busy(busy), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  // strobes = {f_sync, sync, endLine, endFrame, pix_valid, busy, mode_err}
  typedef struct {
    logic       s;
    logic       a;
    logic       r;
    logic [2:0] m;
    logic [6:0] strobes;
    int         pix;
    int         line;
    logic [2:0] md;
  } vec_t;

  vec_t vecs[19];

  task automatic set_row(input int i, input logic s, input logic [6:0] st,
                         input int pix, input int line, input logic [2:0] md);
    vecs[i].s = s; vecs[i].a = 1'b0; vecs[i].r = 1'b1; vecs[i].m = 3'd1;
    vecs[i].strobes = st; vecs[i].pix = pix; vecs[i].line = line; vecs[i].md = md;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] snap();
    return {3'b0, f_sync, sync, endLine, endFrame, pix_valid, busy, mode_err,
            pix_cnt, line_cnt, Mode};
  endfunction

  // One cycle: drive inputs mid-cycle (negedge), then settle before sampling.
  task automatic cyc(input logic s, input logic a, input logic r, input logic [2:0] m);
    @(negedge clk);
    start = s; abort = a; ready = r; mode_in = m;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1; mode_in = 3'd0;

    // Nominal frame, cycle 0 = start sampled.
    set_row(0,  1, 7'b0000000, 0, 0, 3'd0);
    set_row(1,  0, 7'b1100010, 0, 0, 3'd0);
    set_row(2,  0, 7'b0000110, 0, 0, 3'd1);
    set_row(3,  0, 7'b0000110, 1, 0, 3'd1);
    set_row(4,  0, 7'b0000110, 2, 0, 3'd1);
    set_row(5,  0, 7'b0010110, 3, 0, 3'd1);
    set_row(6,  0, 7'b0000010, 0, 0, 3'd1);
    set_row(7,  0, 7'b0100010, 0, 0, 3'd1);
    set_row(8,  0, 7'b0000110, 0, 1, 3'd1);
    set_row(9,  0, 7'b0000110, 1, 1, 3'd1);
    set_row(10, 0, 7'b0000110, 2, 1, 3'd1);
    set_row(11, 0, 7'b0010110, 3, 1, 3'd1);
    set_row(12, 0, 7'b0000010, 0, 1, 3'd1);
    set_row(13, 0, 7'b0100010, 0, 1, 3'd1);
    set_row(14, 0, 7'b0000110, 0, 2, 3'd1);
    set_row(15, 0, 7'b0000110, 1, 2, 3'd1);
    set_row(16, 0, 7'b0000110, 2, 2, 3'd1);
    set_row(17, 0, 7'b0011110, 3, 2, 3'd1);
`ifdef CONTINUOUS_EN
    set_row(18, 0, 7'b1100010, 0, 0, 3'd1);
`else
    set_row(18, 0, 7'b0000000, 0, 0, 3'd1);
`endif

    // Reset state.
    @(negedge clk); #1;
    check("reset_state", snap(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      logic [31:0] exp;
      cyc(vecs[i].s, vecs[i].a, vecs[i].r, vecs[i].m);
      exp = {3'b0, vecs[i].strobes, PW'(vecs[i].pix), LW'(vecs[i].line), vecs[i].md};
      check($sformatf("frame_c%0d", i), snap(), exp);
    end
    cyc(0, 1, 1, 3'd1);  // return to IDLE in either build
    cyc(0, 0, 1, 3'd1);
    check("idle_after_frame_busy", {31'b0, busy}, 32'd0);

    // Ready stall in line 0: pix_cnt 0,1,1,2,2 then endLine once pix 3 is accepted.
    cyc(1, 0, 1, 3'd1);
    cyc(0, 0, 1, 3'd1);
    cyc(0, 0, 1, 3'd1); check("stall_pix_c2", 32'(pix_cnt), 32'd0);
    cyc(0, 0, 0, 3'd1); check("stall_pix_c3", 32'(pix_cnt), 32'd1);
    cyc(0, 0, 1, 3'd1); check("stall_pix_c4", 32'(pix_cnt), 32'd1);
    cyc(0, 0, 0, 3'd1); check("stall_pix_c5", 32'(pix_cnt), 32'd2);
    cyc(0, 0, 1, 3'd1); check("stall_pix_c6", {pix_cnt, 20'b0, endLine}, {PW'(2), 20'b0, 1'b0});
    cyc(0, 0, 1, 3'd1); check("stall_endline_c7", {pix_cnt, 20'b0, endLine}, {PW'(3), 20'b0, 1'b1});
    // Abort in the last blank cycle suppresses the sync pulse.
    cyc(0, 0, 1, 3'd1); check("blank0_sync", {30'b0, pix_valid, sync}, 32'd0);
    cyc(0, 1, 1, 3'd1); check("abort_blank_sync", {31'b0, sync}, 32'd0);
    cyc(0, 0, 1, 3'd1); check("abort_blank_idle", snap() & 32'h1FFF_FFF8, 32'h0);

    // Abort on the final beat of a line beats endLine.
    cyc(1, 0, 1, 3'd1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 3'd1);
    cyc(0, 1, 1, 3'd1); check("abort_beats_endline", {30'b0, endLine, pix_valid}, 32'd1);
    cyc(0, 0, 1, 3'd1); check("abort_line_idle", {30'b0, busy, pix_valid}, 32'd0);

    // Rejected start, and start together with abort.
    cyc(1, 0, 1, 3'd0); check("merr_c0", {30'b0, mode_err, busy}, 32'd0);
    cyc(0, 0, 1, 3'd0); check("merr_pulse", {30'b0, mode_err, busy}, 32'd2);
    cyc(0, 0, 1, 3'd0); check("merr_clear", {30'b0, mode_err, busy}, 32'd0);
    cyc(1, 1, 1, 3'd2);
    cyc(0, 0, 1, 3'd2); check("start_abort_idle", {31'b0, busy}, 32'd0);

    // Mode latched at FSYNC holds while mode_in changes mid-frame.
    cyc(1, 0, 1, 3'd7);
    cyc(0, 0, 1, 3'd7);
    cyc(0, 0, 1, 3'd3); check("mode_c2", 32'(Mode), 32'd7);
    for (int k = 3; k < 17; k++) cyc(0, 0, 1, 3'd3);
    cyc(0, 0, 1, 3'd3); check("mode_c17", {28'b0, endFrame, Mode}, {28'b0, 1'b1, 3'd7});
    cyc(0, 1, 1, 3'd3);
    cyc(0, 0, 1, 3'd3); check("mode_hold_after_abort", 32'(Mode), 32'd7);

    // Asynchronous reset mid-LINE clears outputs at once.
    cyc(1, 0, 1, 3'd1);
    cyc(0, 0, 1, 3'd1);
    cyc(0, 0, 1, 3'd1);
    cyc(0, 0, 1, 3'd1);
    check("pre_reset_busy", {30'b0, busy, pix_valid}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("async_reset", snap(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset", snap(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
